regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Drives the register file's single write port (w_a3, w_d, w_e3) from two writeback producers.
- Producer A is the in-order pipeline WB stage. It cannot stall and always has priority.
- Producer B is the multi-cycle unit (mult/div, late loads). It pushes results through a small FIFO using valid/ready.
- Also exports a pending-write mask for the hazard unit, and a starvation stall request to the pipeline.

Parameters:
- DEPTH, 4, FIFO entries for producer B; power of two, 2..16.
- STARVE_LIMIT, 8, cycles the FIFO head may wait before stall_req asserts; 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  pipeline WB write request.
- a_addr  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- b_valid  in  1  multi-cycle unit result valid.
- b_ready  out  1  FIFO can accept; equals !full, driven from registered count.
- b_addr  in  5  multi-cycle destination register.
- b_data  in  32  multi-cycle result data.
- w_e3  out  1  register file write enable (registered).
- w_a3  out  5  register file write address (registered).
- w_d  out  32  register file write data (registered).
- pending_mask  out  32  bit r set iff a valid FIFO entry targets r; bit 0 always 0.
- stall_req  out  1  asks the pipeline to hold a_valid low so the FIFO can drain (registered).

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, wait counter=0.
  - w_e3=0, w_a3=0, w_d=0, stall_req=0.
  - b_ready=1 from the next cycle; pending_mask=0.
  - Reset mid-operation discards all queued entries; no write is emitted for them.
- Push: b_valid&&b_ready at posedge enqueues {b_addr,b_data}.
  - Entries with b_addr=0 are still enqueued but are dropped when popped: popped, no write.
- Arbitration each cycle (combinational select, registered output):
  - a_valid && a_addr!=0: A wins. Next edge w_e3=1, w_a3=a_addr, w_d=a_data. FIFO holds.
  - a_valid && a_addr==0: treated as no A request; the FIFO may use the slot.
  - Otherwise, if FIFO non-empty: pop head. Next edge w_e3=(head_addr!=0), w_a3/w_d=head.
  - Otherwise: w_e3=0; w_a3/w_d hold their previous values.
- Latency:
  - A: request in cycle n -> write on the register file at edge n+1.
  - B: push at edge n -> earliest pop in cycle n+1 -> w_e3 high after edge n+2.
  - No B-to-output bypass.
- Full: count==DEPTH -> b_ready=0.
  - A pop in the same cycle does not raise b_ready until the next cycle.
  - Push while full is impossible by handshake.
- Empty with simultaneous push and pop request: no pop that cycle; the new entry is visible next cycle.
- Pointers: log2(DEPTH) bits with natural wrap; count is log2(DEPTH)+1 bits.
- Starvation:
  - Wait counter increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the head is not popped.
  - Counter clears on pop or when the FIFO is empty.
  - stall_req registers (counter==STARVE_LIMIT) and stays high until the cycle after the head pops.
  - If a_valid arrives while stall_req=1, A still wins; the pipeline is never dropped.
- pending_mask:
  - Combinational OR of one-hot decodes of all valid entries' addresses.
  - Includes an entry being popped this cycle; excludes an entry being pushed this cycle.
- Ordering between A and B writes to the same register is the hazard unit's job, using pending_mask; this block does not reorder.

Decomposition:
- Shared package (mips_pkg):
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
  - Packed wb_req type {addr[4:0], data[31:0]}.
- One natural sub-module, wb_fifo: DEPTH-entry synchronous FIFO.
  - Ports: push/pop/full/empty/count, plus entry-valid and address vectors for the mask.
- Arbiter, output registers, starvation counter and mask decode stay in the top.

Test Plan:
- Reset: hold rst 2 cycles with b_valid=1 -> w_e3=0, w_a3=0, w_d=0, b_ready=1 after release, pending_mask=0, nothing enqueued.
- A only: a_valid=1, a_addr=5, a_data=32'hDEADBEEF in cycle n -> w_e3=1, w_a3=5, w_d=DEADBEEF after edge n+1; a_addr=0 -> w_e3=0.
- B only: push addr 9 data 32'h1234 at edge n, a_valid=0 -> pending_mask=32'h200 from cycle n+1 -> write reg 9 after edge n+2 -> mask 0 the cycle after.
- Full/priority: a_valid=1 (addr 3) continuously; push 4 B entries (addrs 4,5,6,7) -> b_ready=0 after the 4th; no B writes while A is active; pending_mask=32'hF0.
- Starvation: continue the previous case with STARVE_LIMIT=8 -> stall_req=1 eight cycles after the head became waiting; drop a_valid -> entries drain in order 4,5,6,7 on consecutive cycles; stall_req=0 after the first pop.
- Reset mid-drain: 3 entries queued, assert rst -> no further writes, count=0, pending_mask=0, stall_req=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared register-file types for the writeback path.
// Pure declarations: no latency, no flow control.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO for multi-cycle writeback results; a push is
// visible at the head one cycle later; pushes while full and pops while empty are ignored.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_req_t                             push_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(DEPTH):0]              count,
  output logic [DEPTH-1:0]                    ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  logic [PTR_W-1:0] off;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - rd_ptr_q;
      ent_vld[i]  = ({1'b0, off} < count_q);
      ent_addr[i] = mem_q[i].addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline WB (priority, 1-cycle) and a FIFO'd multi-cycle producer onto one RF write port;
// B is backpressured by b_ready=!full, A never stalls but may be asked to via stall_req.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  w_e3,
  output logic [REG_ADDR_W-1:0] w_a3,
  output logic [DATA_W-1:0]     w_d,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  stall_req
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  wb_req_t                          push_req, head;
  logic                             fifo_full, fifo_empty;
  logic [CNT_W-1:0]                 fifo_count;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic                             a_win, pop, push;

  logic                  w_e3_q, w_e3_d;
  logic [REG_ADDR_W-1:0] w_a3_q, w_a3_d;
  logic [DATA_W-1:0]     w_d_q, w_d_d;
  logic                  stall_q, stall_d;
  logic [7:0]            wait_q, wait_d;

  assign a_win    = a_valid && (a_addr != '0);
  assign pop      = !a_win && (fifo_count != '0);
  assign push     = b_valid && b_ready;
  assign b_ready  = !fifo_full;
  assign push_req = '{addr: b_addr, data: b_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  always_comb begin
    w_e3_d = 1'b0;
    w_a3_d = w_a3_q;
    w_d_d  = w_d_q;
    if (a_win) begin
      w_e3_d = 1'b1;
      w_a3_d = a_addr;
      w_d_d  = a_data;
    end else if (pop) begin
      w_e3_d = (head.addr != '0);
      w_a3_d = head.addr;
      w_d_d  = head.data;
    end

    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != LIMIT) begin
      wait_d = wait_q + 8'd1;
    end
    // Held while the starved head is still waiting; drops once it has popped.
    stall_d = (wait_q == LIMIT) && !pop;
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        pending_mask = pending_mask | reg_onehot(ent_addr[i]);
      end
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_e3_q  <= 1'b0;
      w_a3_q  <= '0;
      w_d_q   <= '0;
      stall_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      w_e3_q  <= w_e3_d;
      w_a3_q  <= w_a3_d;
      w_d_q   <= w_d_d;
      stall_q <= stall_d;
      wait_q  <= wait_d;
    end
  end

  assign w_e3      = w_e3_q;
  assign w_a3      = w_a3_q;
  assign w_d       = w_d_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table for the pipeline path,
// scoreboarded reference queue for FIFO traffic, hand sequences for full/starve/reset.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk, rst;
  logic        a_valid, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, w_a3;
  logic [31:0] a_data, b_data, w_d, pending_mask;
  logic        w_e3, stall_req;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .w_e3         (w_e3),
    .w_a3         (w_a3),
    .w_d          (w_d),
    .pending_mask (pending_mask),
    .stall_req    (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_errors = 0;

  // Reference: queued B entries and the writes the register file should see.
  logic [36:0] mq [$];
  logic [36:0] exp_q [$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i][36:32]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic tick();
    logic [36:0] hd;
    logic [36:0] got;
    logic        rdy;
    rdy = (mq.size() < DEPTH);
    if (rst) begin
      mq.delete();
      m_we = 1'b0;
      m_a3 = '0;
      m_d  = '0;
    end else begin
      if (a_valid && a_addr != 5'd0) begin
        m_we = 1'b1;
        m_a3 = a_addr;
        m_d  = a_data;
      end else if (mq.size() != 0) begin
        hd   = mq.pop_front();
        m_we = (hd[36:32] != 5'd0);
        m_a3 = hd[36:32];
        m_d  = hd[31:0];
      end else begin
        m_we = 1'b0;
      end
      if (m_we) exp_q.push_back({m_a3, m_d});
      if (b_valid && rdy) mq.push_back({b_addr, b_data});
    end
    @(posedge clk);
    #1;
    chk("w_e3", w_e3, m_we);
    if (w_e3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got a3=%0d d=%h, expected no write", w_a3, w_d);
      end else begin
        got = exp_q.pop_front();
        chk("sb_addr", w_a3, got[36:32]);
        chk("sb_data", w_d, got[31:0]);
      end
    end else begin
      chk("hold_a3", w_a3, m_a3);
      chk("hold_d", w_d, m_d);
    end
    chk("b_ready", b_ready, rdy_after());
    chk("pending_mask", pending_mask, model_mask());
  endtask

  function automatic logic rdy_after();
    return (mq.size() < DEPTH);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'h00001111, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd9,  32'h00002222, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};
    vecs[5] = '{1'b0, 5'd7,  32'h00000005, 1'b0, 5'd1,  32'h00000000};

    m_we = 1'b0; m_a3 = '0; m_d = '0;
    rst = 1'b1; a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h55;

    // Reset held two cycles with a B request present.
    tick();
    tick();
    chk("rst_w_e3", w_e3, 0);
    chk("rst_w_a3", w_a3, 0);
    chk("rst_w_d", w_d, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_mask", pending_mask, 0);
    rst = 1'b0; b_valid = 1'b0;
    tick();
    chk("rst_noenq_mask", pending_mask, 0);
    chk("rst_noenq_we", w_e3, 0);

    // Pipeline-only vectors with an empty FIFO.
    for (int i = 0; i < 6; i++) begin
      a_valid = vecs[i].a_valid;
      a_addr  = vecs[i].a_addr;
      a_data  = vecs[i].a_data;
      tick();
      chk($sformatf("vec%0d_we", i), w_e3, vecs[i].exp_we);
      chk($sformatf("vec%0d_a3", i), w_a3, vecs[i].exp_a3);
      chk($sformatf("vec%0d_d", i), w_d, vecs[i].exp_d);
    end

    // B only: push, no bypass, write two edges later, mask clears with it.
    a_valid = 1'b0; b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h1234;
    tick();
    chk("b_mask_pushed", pending_mask, 32'h200);
    chk("b_no_bypass", w_e3, 0);
    b_valid = 1'b0;
    tick();
    chk("b_write_we", w_e3, 1);
    chk("b_write_a3", w_a3, 9);
    chk("b_write_d", w_d, 32'h1234);
    chk("b_mask_clear", pending_mask, 0);

    // Zero-address B entry is dropped; A with addr 0 yields the slot.
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hBAD00000;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h000000DD;
    tick();
    chk("zero_mask", pending_mask, 0);
    b_addr = 5'd13; b_data = 32'h1300;
    tick();
    chk("zero_drop_we", w_e3, 0);
    chk("a0_mask13", pending_mask, 32'h2000);
    b_valid = 1'b0;
    tick();
    chk("a0_slot_we", w_e3, 1);
    chk("a0_slot_a3", w_a3, 13);

    // A continuously active: fill the FIFO, then starve the head.
    a_valid = 1'b1; a_addr = 5'd3;
    for (int k = 1; k <= 12; k++) begin
      a_data  = 32'hA0000000 + 32'(k);
      b_valid = (k <= 4);
      b_addr  = 5'(3 + k);
      b_data  = 32'hB0000000 + 32'(3 + k);
      tick();
      chk($sformatf("prio_a3_%0d", k), w_a3, 3);
      chk($sformatf("stall_%0d", k), stall_req, (k >= 10) ? 1 : 0);
      if (k == 4) begin
        chk("full_ready", b_ready, 0);
        chk("full_mask", pending_mask, 32'hF0);
      end
    end

    // Release A: drain 4,5,6,7 on consecutive cycles, stall drops after first pop.
    a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain_we_%0d", k), w_e3, 1);
      chk($sformatf("drain_a3_%0d", k), w_a3, 4 + k);
      chk($sformatf("drain_d_%0d", k), w_d, 32'hB0000000 + 32'(4 + k));
      chk($sformatf("drain_stall_%0d", k), stall_req, 0);
    end
    chk("drained_mask", pending_mask, 0);

    // Reset with three entries queued.
    a_valid = 1'b1; a_addr = 5'd3;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1; b_addr = 5'(10 + k); b_data = 32'hC0000000 + 32'(k);
      tick();
    end
    chk("pre_rst_mask", pending_mask, 32'h1C00);
    b_valid = 1'b0; a_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", dut.fifo_count, 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_stall", stall_req, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post_rst_we_%0d", k), w_e3, 0);
      chk($sformatf("post_rst_ready_%0d", k), b_ready, 1);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
